// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with an elastic
// result buffer between ID and EX.
// Ports: clk, rstn (async, active low), flush (sync), in_valid/in_ready,
//   instr, pc, ext_op (one-hot format), out_valid/out_ready, imm,
//   target (pc + imm), fmt_err.
// Option: define IMM_GEN_CSR_EN to make ext_op[6] select the CSR uimm.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [6:0]      ext_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] target,
  output logic            fmt_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            err;
  } ent_t;

  logic [6:0]      op;
  logic            legal;
  logic [5:0]      shamt;
  logic [31:0]     raw;
  logic [XLEN-1:0] imm_d;
  ent_t            wr_ent;

  // Without the CSR option bit6 simply does not exist for decode.
  always_comb begin
    op = ext_op;
`ifndef IMM_GEN_CSR_EN
    op[6] = 1'b0;
`endif
  end

  assign legal = (op != '0) && ((op & (op - 7'd1)) == '0);

  // shamt[5] only exists on RV64.
  assign shamt = {(XLEN == 64) & instr[25], instr[24:20]};

  // Every format fits in 32 bits, so decode to a signed 32-bit value
  // and sign-extend once; zero-extended formats have bit31 clear.
  always_comb begin
    raw = '0;
    if (legal) begin
      unique case (1'b1)
        op[5]: raw = {26'b0, shamt};
        op[4]: raw = {{20{instr[31]}}, instr[31:20]};
        op[3]: raw = {{20{instr[31]}}, instr[31:25],
                      instr[11:7]};
        op[2]: raw = {{19{instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
        op[1]: raw = {instr[31:12], 12'b0};
        op[0]: raw = {{11{instr[31]}}, instr[31],
                      instr[19:12], instr[20],
                      instr[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
        op[6]: raw = {27'b0, instr[19:15]};
`endif
        default: raw = '0;
      endcase
    end
  end

  assign imm_d      = XLEN'(signed'(raw));
  assign wr_ent.imm    = imm_d;
  assign wr_ent.target = pc + imm_d;
  assign wr_ent.err    = ~legal;

  ent_t           mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  // Readiness looks at count only, so a full buffer refuses a push
  // even in a cycle where the head is being taken.
  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign imm     = mem[rd_ptr].imm;
  assign target  = mem[rd_ptr].target;
  assign fmt_err = mem[rd_ptr].err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: bench for imm_gen_pipe, one XLEN=32/DEPTH=2 instance
// and one XLEN=64/DEPTH=3 instance checked against a queue model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic        a_in_ready, a_out_valid, a_err;
  logic [31:0] a_instr = 0, a_pc = 0, a_imm, a_target;
  logic [6:0]  a_op = 0;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic        b_in_ready, b_out_valid, b_err;
  logic [31:0] b_instr = 0;
  logic [63:0] b_pc = 0, b_imm, b_target;
  logic [6:0]  b_op = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_a (
    .clk(clk), .rstn(rstn), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr(a_instr), .pc(a_pc), .ext_op(a_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm(a_imm), .target(a_target), .fmt_err(a_err)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(3)) u_b (
    .clk(clk), .rstn(rstn), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .pc(b_pc), .ext_op(b_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm(b_imm), .target(b_target), .fmt_err(b_err)
  );

  localparam logic [6:0] OP_J   = 7'b0000001;
  localparam logic [6:0] OP_U   = 7'b0000010;
  localparam logic [6:0] OP_B   = 7'b0000100;
  localparam logic [6:0] OP_I   = 7'b0010000;
  localparam logic [6:0] OP_SH  = 7'b0100000;
  localparam logic [6:0] OP_CSR = 7'b1000000;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        err;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference decode: field values as integers, sign applied by
  // subtracting the field's range, result reduced modulo 2^xlen.
  function automatic ent_t ref_ent(input logic [31:0] ins,
                                   input logic [63:0] p,
                                   input logic [6:0] op,
                                   input int xlen);
    logic [6:0]  eff;
    logic [63:0] m;
    longint      v;
    ent_t        e;
    eff = op;
`ifndef IMM_GEN_CSR_EN
    eff[6] = 1'b0;
`endif
    m = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    v = 0;
    e.err = ($countones(eff) != 1);
    if (!e.err) begin
      if (eff[5]) begin
        v = (xlen == 32) ? longint'(ins[24:20])
                         : longint'(ins[25:20]);
      end else if (eff[4]) begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end else if (eff[3]) begin
        v = longint'({ins[31:25], ins[11:7]});
        if (v >= 2048) v -= 4096;
      end else if (eff[2]) begin
        v = longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
        if (v >= 4096) v -= 8192;
      end else if (eff[1]) begin
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= (longint'(1) << 32);
      end else if (eff[0]) begin
        v = longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
      end else begin
        v = longint'(ins[19:15]);
      end
    end
    e.imm = 64'(v) & m;
    e.tgt = (p + e.imm) & m;
    return e;
  endfunction

  function automatic logic [6:0] rnd_op();
    if ($urandom_range(3) != 0) return 7'd1 << $urandom_range(6);
    return 7'($urandom);
  endfunction

  function automatic logic [130:0] exp_a();
    ent_t h;
    h.imm = '0; h.tgt = '0; h.err = 1'b0;
    if (qa.size() > 0) h = qa[0];
    return {qa.size() < 2, qa.size() > 0, h.imm, h.tgt, h.err};
  endfunction

  function automatic logic [130:0] obs_a();
    return {a_in_ready, a_out_valid,
            a_out_valid ? 64'(a_imm) : 64'h0,
            a_out_valid ? 64'(a_target) : 64'h0,
            a_out_valid & a_err};
  endfunction

  function automatic logic [130:0] exp_b();
    ent_t h;
    h.imm = '0; h.tgt = '0; h.err = 1'b0;
    if (qb.size() > 0) h = qb[0];
    return {qb.size() < 3, qb.size() > 0, h.imm, h.tgt, h.err};
  endfunction

  function automatic logic [130:0] obs_b();
    return {b_in_ready, b_out_valid,
            b_out_valid ? b_imm : 64'h0,
            b_out_valid ? b_target : 64'h0,
            b_out_valid & b_err};
  endfunction

  // Drive one cycle from a negedge, advance the model, return at the
  // next negedge with inputs idled.
  task automatic drive_a(input logic v, input logic [31:0] ins,
                         input logic [31:0] p, input logic [6:0] op,
                         input logic ordy, input logic fl);
    bit push, pop;
    a_in_valid = v; a_instr = ins; a_pc = p; a_op = op;
    a_out_ready = ordy; a_flush = fl;
    push = v && (qa.size() < 2);
    pop  = (qa.size() > 0) && ordy;
    if (fl) qa.delete();
    else begin
      if (pop) void'(qa.pop_front());
      if (push) qa.push_back(ref_ent(ins, 64'(p), op, 32));
    end
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 0; a_flush = 0;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ins,
                         input logic [63:0] p, input logic [6:0] op,
                         input logic ordy, input logic fl);
    bit push, pop;
    b_in_valid = v; b_instr = ins; b_pc = p; b_op = op;
    b_out_ready = ordy; b_flush = fl;
    push = v && (qb.size() < 3);
    pop  = (qb.size() > 0) && ordy;
    if (fl) qb.delete();
    else begin
      if (pop) void'(qb.pop_front());
      if (push) qb.push_back(ref_ent(ins, p, op, 64));
    end
    @(negedge clk);
    b_in_valid = 0; b_out_ready = 0; b_flush = 0;
  endtask

  task automatic test_reset();
    logic [66:0] ga;
    logic [130:0] gb;
    rstn = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    ga = {a_in_ready, a_out_valid, a_imm, a_target, a_err};
    n_cmp++;
    if (ga !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a got=%h want=%h", ga,
               {1'b1, 1'b0, 32'h0, 32'h0, 1'b0});
    end
    gb = {b_in_ready, b_out_valid, b_imm, b_target, b_err};
    n_cmp++;
    if (gb !== {1'b1, 1'b0, 64'h0, 64'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_b got=%h want=%h", gb,
               {1'b1, 1'b0, 64'h0, 64'h0, 1'b0});
    end
  endtask

  task automatic test_formats();
    logic [31:0] ins [5] = '{32'hFE000EE3, 32'h0080006F,
                             32'h12345037, 32'h01F0D093, 32'h00000013};
    logic [6:0]  ops [5] = '{OP_B, OP_J, OP_U, OP_SH, 7'b0000110};
    logic [31:0] ei  [5] = '{32'hFFFF_FFFC, 32'h8, 32'h1234_5000,
                             32'd31, 32'h0};
    logic [31:0] et  [5] = '{32'h0000_0FFC, 32'h1008, 32'h1234_6000,
                             32'h101F, 32'h1000};
    logic        ee  [5] = '{0, 0, 0, 0, 1};
    logic [65:0] g, w;
    for (int i = 0; i < 5; i++) begin
      drive_a(1, ins[i], 32'h1000, ops[i], 1, 0);
      g = {a_out_valid, a_imm, a_target, a_err};
      w = {1'b1, ei[i], et[i], ee[i]};
      n_cmp++;
      if (g !== w) begin
        n_bad++;
        $display("FAIL format_%0d got=%h want=%h", i, g, w);
      end
      n_cmp++;
      if (obs_a() !== exp_a()) begin
        n_bad++;
        $display("FAIL format_model_%0d got=%h want=%h",
                 i, obs_a(), exp_a());
      end
    end
    drive_a(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_xlen64();
    logic [128:0] g, w;
    drive_b(1, 32'h80000037, 64'hFFFF_FFFF_FFFF_FFF0, OP_U, 1, 0);
    g = {b_out_valid, b_imm, b_target, b_err};
    w = {1'b1, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_7FFF_FFF0, 1'b0};
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL x64_u got=%h want=%h", g, w);
    end
    drive_b(1, 32'h03F0D093, 64'h0, OP_SH, 1, 0);
    g = {b_out_valid, b_imm, b_target, b_err};
    w = {1'b1, 64'd63, 64'd63, 1'b0};
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL x64_shamt got=%h want=%h", g, w);
    end
    drive_b(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] ins;
    logic [63:0] p;
    logic [6:0]  op;
    logic        pend, acc;
    for (int i = 0; i < 4; i++) begin
      ins = $urandom; p = {$urandom, $urandom}; op = rnd_op();
      drive_b(1, ins, p, op, 0, 0);
      n_cmp++;
      if (b_in_ready !== (i < 2)) begin
        n_bad++;
        $display("FAIL bp_ready_%0d got=%b want=%b",
                 i, b_in_ready, i < 2);
      end
      n_cmp++;
      if (obs_b() !== exp_b()) begin
        n_bad++;
        $display("FAIL bp_fill_%0d got=%h want=%h",
                 i, obs_b(), exp_b());
      end
    end
    pend = 1;
    for (int c = 0; c < 8; c++) begin
      acc = pend && b_in_ready;
      drive_b(pend, ins, p, op, 1, 0);
      if (acc) pend = 0;
      n_cmp++;
      if (obs_b() !== exp_b()) begin
        n_bad++;
        $display("FAIL bp_drain_%0d got=%h want=%h",
                 c, obs_b(), exp_b());
      end
    end
    n_cmp++;
    if ({pend, b_out_valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL bp_done got=%b want=00", {pend, b_out_valid});
    end
  endtask

  task automatic test_flush();
    drive_a(1, $urandom, $urandom, OP_I, 0, 0);
    drive_a(1, $urandom, $urandom, OP_B, 0, 0);
    n_cmp++;
    if ({a_in_ready, a_out_valid} !== 2'b01) begin
      n_bad++;
      $display("FAIL flush_fill got=%b want=01",
               {a_in_ready, a_out_valid});
    end
    drive_a(1, $urandom, $urandom, OP_J, 1, 1);
    n_cmp++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL flush_now got=%b want=10",
               {a_in_ready, a_out_valid});
    end
    drive_a(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL flush_after got=%b want=10",
               {a_in_ready, a_out_valid});
    end
  endtask

  task automatic test_reset_mid();
    drive_a(1, $urandom, $urandom, OP_U, 0, 0);
    drive_a(1, $urandom, $urandom, OP_S(), 0, 0);
    #2 rstn = 0;
    #1;
    qa.delete();
    qb.delete();
    n_cmp++;
    if ({a_in_ready, a_out_valid, a_imm} !== {2'b10, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid got=%h want=%h",
               {a_in_ready, a_out_valid, a_imm}, {2'b10, 32'h0});
    end
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  function automatic logic [6:0] OP_S();
    return 7'b0001000;
  endfunction

  task automatic test_csr();
    logic [65:0] g, w;
`ifdef IMM_GEN_CSR_EN
    w = {1'b1, 32'd31, 32'h21F, 1'b0};
`else
    w = {1'b1, 32'd0, 32'h200, 1'b1};
`endif
    drive_a(1, 32'h000F8073, 32'h200, OP_CSR, 1, 0);
    g = {a_out_valid, a_imm, a_target, a_err};
    n_cmp++;
    if (g !== w) begin
      n_bad++;
      $display("FAIL csr got=%h want=%h", g, w);
    end
    drive_a(1, 32'hFFF00013, 32'h200, OP_CSR | OP_I, 1, 0);
    n_cmp++;
    if (obs_a() !== exp_a()) begin
      n_bad++;
      $display("FAIL csr_mix got=%h want=%h", obs_a(), exp_a());
    end
    drive_a(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_random_a();
    for (int c = 0; c < 250; c++) begin
      drive_a($urandom_range(3) != 0, $urandom, $urandom, rnd_op(),
              $urandom_range(4) > 1, $urandom_range(19) == 0);
      n_cmp++;
      if (obs_a() !== exp_a()) begin
        n_bad++;
        $display("FAIL rand_a_%0d got=%h want=%h",
                 c, obs_a(), exp_a());
      end
    end
  endtask

  task automatic test_random_b();
    logic [63:0] p;
    for (int c = 0; c < 250; c++) begin
      p = {$urandom, $urandom};
      if ($urandom_range(1) == 0) p[63:20] = '1;
      drive_b($urandom_range(3) != 0, $urandom, p, rnd_op(),
              $urandom_range(4) > 1, $urandom_range(19) == 0);
      n_cmp++;
      if (obs_b() !== exp_b()) begin
        n_bad++;
        $display("FAIL rand_b_%0d got=%h want=%h",
                 c, obs_b(), exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_csr();
    test_random_a();
    test_random_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
